// File: rtl/riscv_pkg.sv
// Shared register-file types: widths, writeback entry and the drain/dump FSM states.
package riscv_pkg;
   localparam int REGISTER_WIDTH   = 64;
   localparam int REGISTERNO_WIDTH = 5;
   localparam int NUM_REGS         = 32;

   typedef struct packed {
      logic [REGISTERNO_WIDTH-1:0] regno;
      logic [REGISTER_WIDTH-1:0]   value;
   } wb_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_DUMP,
      ST_DONE
   } dump_state_t;
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; exposes every slot plus a
// per-slot valid bit so the owner can build a pending-register mask.
module wb_fifo
   import riscv_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = wb_entry_t
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  entry_t                     push_data,
   input  logic                       pop,
   output entry_t                     head,
   output logic [$clog2(DEPTH):0]     count,
   output entry_t [DEPTH-1:0]         slots,
   output logic [DEPTH-1:0]           slot_valid
);
   localparam int PW = $clog2(DEPTH);

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   off;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   assign head = mem[rd_ptr];

   // Slot i is live when its distance from the read pointer is below count.
   always_comb begin
      off        = '0;
      slot_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slots[i]      = mem[i];
         off           = PW'(i) - rd_ptr;
         slot_valid[i] = {1'b0, off} < count;
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback scheduler for the single-write-port register file,
// with a drain-then-dump sequencer ahead of the end-of-run register display.
module regfile_wb_arbiter
   import riscv_pkg::*;
#(
   parameter int REGISTER_WIDTH   = riscv_pkg::REGISTER_WIDTH,
   parameter int REGISTERNO_WIDTH = riscv_pkg::REGISTERNO_WIDTH,
   parameter int FIFO_DEPTH       = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req0_valid,
   output logic                        req0_ready,
   input  logic [REGISTERNO_WIDTH-1:0] req0_regno,
   input  logic [REGISTER_WIDTH-1:0]   req0_value,
   input  logic                        req1_valid,
   output logic                        req1_ready,
   input  logic [REGISTERNO_WIDTH-1:0] req1_regno,
   input  logic [REGISTER_WIDTH-1:0]   req1_value,
   input  logic                        dump_req,
   output logic                        dump_busy,
   output logic [NUM_REGS-1:0]         pending_mask,
   output logic                        rf_wr_enable,
   output logic [REGISTERNO_WIDTH-1:0] rf_rd_regno,
   output logic [REGISTER_WIDTH-1:0]   rf_rd_value,
   output logic                        rf_display_regs
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [REGISTERNO_WIDTH-1:0] regno;
      logic [REGISTER_WIDTH-1:0]   value;
   } entry_t;

   dump_state_t                  state, state_next;
   entry_t                       head0, head1, gnt_entry;
   entry_t [FIFO_DEPTH-1:0]      slots0, slots1;
   logic   [FIFO_DEPTH-1:0]      sv0, sv1;
   logic   [CW-1:0]              cnt0, cnt1;
   logic                         arb_on, ne0, ne1, grant0, grant1;
   logic                         last_gnt;

   assign req0_ready = (cnt0 < CW'(FIFO_DEPTH)) && (state == ST_IDLE);
   assign req1_ready = (cnt1 < CW'(FIFO_DEPTH)) && (state == ST_IDLE);

   wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo0 (
      .clk(clk), .reset(reset),
      .push(req0_valid && req0_ready), .push_data({req0_regno, req0_value}),
      .pop(grant0), .head(head0), .count(cnt0), .slots(slots0), .slot_valid(sv0)
   );

   wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo1 (
      .clk(clk), .reset(reset),
      .push(req1_valid && req1_ready), .push_data({req1_regno, req1_value}),
      .pop(grant1), .head(head1), .count(cnt1), .slots(slots1), .slot_valid(sv1)
   );

   // last_gnt names the source granted last; on contention the other one wins.
   assign arb_on    = (state == ST_IDLE) || (state == ST_DRAIN);
   assign ne0       = (cnt0 != '0);
   assign ne1       = (cnt1 != '0);
   assign grant0    = arb_on && ne0 && (!ne1 || last_gnt);
   assign grant1    = arb_on && ne1 && (!ne0 || !last_gnt);
   assign gnt_entry = grant1 ? head1 : head0;

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_wr_enable <= 1'b0;
         rf_rd_regno  <= '0;
         rf_rd_value  <= '0;
         last_gnt     <= 1'b1;
      end else begin
         rf_wr_enable <= (grant0 || grant1) && (gnt_entry.regno != '0);
         if ((grant0 || grant1) && (gnt_entry.regno != '0)) begin
            rf_rd_regno <= gnt_entry.regno;
            rf_rd_value <= gnt_entry.value;
         end
         if (grant0 || grant1) last_gnt <= grant1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (dump_req) state_next = ST_DRAIN;
         ST_DRAIN: if (!ne0 && !ne1 && !rf_wr_enable) state_next = ST_DUMP;
         ST_DUMP:  state_next = ST_DONE;
         default:  state_next = ST_DONE;
      endcase
   end

   assign rf_display_regs = (state == ST_DUMP);
   assign dump_busy       = (state != ST_IDLE);

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (sv0[i]) pending_mask[slots0[i].regno] = 1'b1;
         if (sv1[i]) pending_mask[slots1[i].regno] = 1'b1;
      end
      if (rf_wr_enable) pending_mask[rf_rd_regno] = 1'b1;
      pending_mask[0] = 1'b0;
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_regfile_wb_arbiter;
   localparam int D = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [4:0]  req0_regno, req1_regno, rf_rd_regno;
   logic [63:0] req0_value, req1_value, rf_rd_value;
   logic        dump_req, dump_busy, rf_wr_enable, rf_display_regs;
   logic [31:0] pending_mask;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   regfile_wb_arbiter #(.REGISTER_WIDTH(64), .REGISTERNO_WIDTH(5), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_regno(req0_regno), .req0_value(req0_value),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_regno(req1_regno), .req1_value(req1_value),
      .dump_req(dump_req), .dump_busy(dump_busy), .pending_mask(pending_mask),
      .rf_wr_enable(rf_wr_enable), .rf_rd_regno(rf_rd_regno), .rf_rd_value(rf_rd_value),
      .rf_display_regs(rf_display_regs)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  r;
      logic [63:0] v;
   } ent_t;

   // Reference model: one queue per source, a "last granted" source, a phase
   // (0 idle, 1 drain, 2 dump, 3 done) and the write it predicts on the port.
   ent_t        q0[$], q1[$];
   int          last, phase, g;
   bit          m_en, old_en, r0, r1, e0, e1;
   logic [4:0]  m_rg;
   logic [63:0] m_val;
   ent_t        e;

   logic [63:0] log_v[$];
   int          log_c[$];
   bit          check_on = 0;
   bit          seen_nr0 = 0;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         q0.delete(); q1.delete();
         last = 1; phase = 0; m_en = 0; m_rg = '0; m_val = '0;
      end else begin
         r0 = (q0.size() < D) && (phase == 0);
         r1 = (q1.size() < D) && (phase == 0);
         e0 = (q0.size() == 0);
         e1 = (q1.size() == 0);
         old_en = m_en;
         g = -1;
         if (phase <= 1) begin
            if (!e0 && !e1) g = (last == 0) ? 1 : 0;
            else if (!e0)   g = 0;
            else if (!e1)   g = 1;
         end
         m_en = 0;
         if (g >= 0) begin
            e = (g == 0) ? q0.pop_front() : q1.pop_front();
            last = g;
            if (e.r != 0) begin m_en = 1; m_rg = e.r; m_val = e.v; end
         end
         if (req0_valid && r0) q0.push_back('{req0_regno, req0_value});
         if (req1_valid && r1) q1.push_back('{req1_regno, req1_value});
         case (phase)
            0: if (dump_req) phase = 1;
            1: if (e0 && e1 && !old_en) phase = 2;
            2: phase = 3;
            default: ;
         endcase
      end
   end

   function automatic logic [31:0] exp_mask();
      logic [31:0] m = '0;
      foreach (q0[i]) m[q0[i].r] = 1'b1;
      foreach (q1[i]) m[q1[i].r] = 1'b1;
      if (m_en) m[m_rg] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (check_on) begin
         chk("req0_ready", req0_ready, (q0.size() < D) && (phase == 0));
         chk("req1_ready", req1_ready, (q1.size() < D) && (phase == 0));
         chk("rf_wr_enable", rf_wr_enable, m_en);
         if (m_en) begin
            chk("rf_rd_regno", rf_rd_regno, m_rg);
            chk("rf_rd_value", rf_rd_value, m_val);
         end
         chk("rf_display_regs", rf_display_regs, phase == 2);
         chk("dump_busy", dump_busy, phase != 0);
         chk("pending_mask", pending_mask, exp_mask());
         chk("wr_display_exclusive", rf_wr_enable && rf_display_regs, 0);
         if (rf_wr_enable === 1'b1) begin log_v.push_back(rf_rd_value); log_c.push_back(cyc); end
         if (req0_ready === 1'b0 && dump_busy === 1'b0) seen_nr0 = 1;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      log_v.delete(); log_c.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Both sources offer entries back to back, holding each until accepted.
   task automatic stream(input int n0, input int n1, input int b0, input int b1,
                         input int rg0, input int rg1, input int wrap);
      int i0, i1, guard;
      bit a0, a1;
      i0 = 0; i1 = 0; guard = 0;
      while ((i0 < n0 || i1 < n1) && guard < 200) begin
         req0_valid = (i0 < n0);
         req0_regno = 5'(rg0 + (i0 % wrap));
         req0_value = 64'(b0 + i0);
         req1_valid = (i1 < n1);
         req1_regno = 5'(rg1 + (i1 % wrap));
         req1_value = 64'(b1 + i1);
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         @(negedge clk);
         if (a0) i0++;
         if (a1) i1++;
         guard++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("stream_timeout", guard >= 200, 0);
   endtask

   initial begin
      logic [63:0] exp_c [8];
      int disp_cnt, n_lo, n_hi;
      bit order_ok;
      exp_c = '{64'h10, 64'h20, 64'h11, 64'h21, 64'h12, 64'h22, 64'h13, 64'h23};

      reset = 1'b1; dump_req = 1'b0;
      req0_valid = 1'b0; req0_regno = '0; req0_value = '0;
      req1_valid = 1'b0; req1_regno = '0; req1_value = '0;
      idle(2);
      reset = 1'b0;
      check_on = 1;
      chk("reset_ready0", req0_ready, 1);
      chk("reset_ready1", req1_ready, 1);
      chk("reset_wr_en", rf_wr_enable, 0);
      chk("reset_mask", pending_mask, 0);
      chk("reset_busy", dump_busy, 0);

      // single write
      req0_valid = 1'b1; req0_regno = 5'd5; req0_value = 64'h1234;
      @(negedge clk);
      req0_valid = 1'b0;
      chk("single_mask_edge0", pending_mask, 32'h20);
      chk("single_wr_en_early", rf_wr_enable, 0);
      @(negedge clk);
      chk("single_wr_en", rf_wr_enable, 1);
      chk("single_regno", rf_rd_regno, 5);
      chk("single_value", rf_rd_value, 64'h1234);
      chk("single_mask_out", pending_mask, 32'h20);
      @(negedge clk);
      chk("single_wr_en_after", rf_wr_enable, 0);
      chk("single_mask_after", pending_mask, 0);

      // contention, alternating grants starting with requester 0
      do_reset();
      stream(4, 4, 'h10, 'h20, 1, 8, 4);
      idle(4);
      chk("cont_count", log_v.size(), 8);
      if (log_v.size() == 8) begin
         for (int i = 0; i < 8; i++) chk("cont_order", log_v[i], exp_c[i]);
         chk("cont_back_to_back", log_c[7] - log_c[0], 7);
      end

      // backpressure with ten entries per source
      do_reset();
      seen_nr0 = 0;
      stream(10, 10, 'h100, 'h200, 1, 16, 8);
      idle(6);
      chk("bp_total", log_v.size(), 20);
      chk("bp_ready_dropped", seen_nr0, 1);
      n_lo = 0; n_hi = 0; order_ok = 1;
      foreach (log_v[i]) begin
         if (log_v[i] < 'h200) begin
            if (log_v[i] != 64'('h100 + n_lo)) order_ok = 0;
            n_lo++;
         end else begin
            if (log_v[i] != 64'('h200 + n_hi)) order_ok = 0;
            n_hi++;
         end
      end
      chk("bp_per_source_order", order_ok, 1);

      // x0 write is swallowed, the next entry still writes
      do_reset();
      stream(0, 2, 0, 'hFF, 0, 0, 4);
      idle(4);
      chk("x0_writes", log_v.size(), 1);
      if (log_v.size() == 1) chk("x0_next_value", log_v[0], 64'h100);

      // drain then dump
      do_reset();
      stream(1, 1, 'h70, 'h80, 3, 4, 4);
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      chk("dump_ready0_low", req0_ready, 0);
      chk("dump_ready1_low", req1_ready, 0);
      chk("dump_busy_set", dump_busy, 1);
      disp_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (rf_display_regs === 1'b1) begin
            disp_cnt++;
            chk("dump_writes_before_display", log_v.size(), 2);
         end
         @(negedge clk);
      end
      chk("dump_display_pulses", disp_cnt, 1);
      chk("dump_busy_held", dump_busy, 1);
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      chk("dump_done_ready0", req0_ready, 0);

      // reset in the middle of buffered traffic
      do_reset();
      req0_valid = 1'b1; req0_regno = 5'd6; req0_value = 64'h61;
      req1_valid = 1'b1; req1_regno = 5'd7; req1_value = 64'h71;
      @(negedge clk);
      req1_valid = 1'b0; req0_value = 64'h62;
      @(negedge clk);
      req0_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      log_v.delete(); log_c.delete();
      for (int i = 0; i < 4; i++) begin
         chk("rst_no_write", rf_wr_enable, 0);
         chk("rst_mask", pending_mask, 0);
         chk("rst_ready0", req0_ready, 1);
         @(negedge clk);
      end
      stream(1, 1, 'h50, 'h60, 2, 3, 4);
      idle(4);
      chk("rst_writes", log_v.size(), 2);
      if (log_v.size() == 2) chk("rst_first_grant_src0", log_v[0], 64'h50);

      check_on = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writeback scheduler for the 32-entry integer register file, which has a single write port. Two writeback sources, requester 0 (ALU) and requester 1 (load unit), each get a small FIFO. A round-robin arbiter shares the write port between them and drives it from a registered output stage. A drain/dump sequencer empties all pending writes before pulsing the register file's display request, so a write and a display never coincide.

Parameters:
REGISTER_WIDTH, 64, data width of a register value
REGISTERNO_WIDTH, 5, register index width
FIFO_DEPTH, 2, entries per requester FIFO; power of two, at least 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a writeback
req0_ready  out  1  requester 0 entry accepted this cycle if valid
req0_regno  in  REGISTERNO_WIDTH  destination register
req0_value  in  REGISTER_WIDTH  value to write
req1_valid  in  1  requester 1 has a writeback
req1_ready  out  1  requester 1 entry accepted this cycle if valid
req1_regno  in  REGISTERNO_WIDTH  destination register
req1_value  in  REGISTER_WIDTH  value to write
dump_req  in  1  request the end-of-run register dump
dump_busy  out  1  drain/dump in progress or done
pending_mask  out  32  bit r set while a write to register r is buffered or in the output stage
rf_wr_enable  out  1  register file write enable
rf_rd_regno  out  REGISTERNO_WIDTH  register file write index
rf_rd_value  out  REGISTER_WIDTH  register file write data
rf_display_regs  out  1  register file dump request

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values: all outputs 0 except req0_ready and req1_ready, which are 1. FIFOs empty, RR pointer favours requester 0, FSM in IDLE.
- Reset mid-operation discards all buffered and in-flight writes. No rf_wr_enable appears after reset.
- reqN_ready = (countN < FIFO_DEPTH) && state==IDLE. It comes from registers only and never depends on reqN_valid.
- Push happens on the edge where valid && ready. Ready is low when full, so a simultaneous push and pop on a full FIFO cannot occur.
- Arbitration: each cycle with state in IDLE or DRAIN and at least one FIFO non-empty, grant one FIFO head and pop it at the edge.
  - If only one FIFO is non-empty, grant it.
  - If both are non-empty, grant the one not granted last.
  - The pointer updates only on a grant.
- Output stage: on a grant with regno != 0, at the edge set rf_wr_enable=1 and load rf_rd_regno/rf_rd_value. Otherwise rf_wr_enable=0.
- An x0 entry is popped and consumes the grant slot and the pointer update, but produces no write.
- Latency: push at edge T, grant/pop at edge T+1, rf_wr_enable high during cycle T+1..T+2, register file write at edge T+2.
- Throughput: one write per cycle in total.
- Order is preserved within a source. Across sources, order equals grant order. Upstream must not rely on cross-source ordering to the same register.
- pending_mask is combinational over valid FIFO entries plus the output stage when rf_wr_enable=1. Bit 0 is always 0.
- FSM:
  - IDLE -> DRAIN when dump_req=1.
  - DRAIN: both readys are 0; arbitration continues. DRAIN -> DUMP when both FIFOs are empty and the output stage is idle (rf_wr_enable=0 at the edge).
  - DUMP: rf_display_regs=1 for exactly one cycle with rf_wr_enable=0, then -> DONE.
  - DONE is terminal until reset. Readys stay 0.
  - dump_busy = (state != IDLE).
- rf_wr_enable and rf_display_regs are never high in the same cycle.
- dump_req while busy is ignored.

Decomposition:
- Shared package (riscv_pkg): REGISTER_WIDTH, REGISTERNO_WIDTH, NUM_REGS=32, wb_entry_t struct {regno, value}, dump FSM state enum.
- One sub-module, wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/count/valid-entry outputs for the mask. Instantiated twice.

Test Plan:
- Single write: req0 regno 5, value 0x1234 pushed at edge 0 -> rf_wr_enable=1, regno 5, value 0x1234 in the cycle after edge 1. pending_mask[5]=1 from after edge 0 through that cycle, then 0.
- Contention: both valid continuously, 4 entries each (values 0x10..0x13 and 0x20..0x23) -> writes alternate 0x10,0x20,0x11,0x21,... for 8 consecutive cycles. Per-source order is kept.
- Backpressure: both stream 10 entries every cycle -> a ready deasserts when its FIFO reaches FIFO_DEPTH. All 20 writes appear with none lost or duplicated, and no push is accepted while ready=0.
- x0 write: req1 regno 0, value 0xFF -> rf_wr_enable stays 0, pending_mask stays 0, and the next req1 entry is granted the following cycle.
- Dump: buffer 2 writes, assert dump_req -> readys go 0 next cycle, both writes issue, then rf_display_regs pulses one cycle with rf_wr_enable=0, and dump_busy stays 1.
- Reset mid-operation: 3 buffered entries, then reset for 1 cycle -> no rf_wr_enable afterwards, pending_mask=0, readys=1, and the next contention grants requester 0 first.
